pop_sample_accumulator: RTL
===========================

// Module: pop_sample_accumulator
// PURPOSE
//  Downstream consumer of the POP timer 'sample' gate. Integrates ADC samples taken
//  while the gate is high, once per POP cycle (one window), and sums NUM_CYCLES
//  consecutive windows into one result. Results are offered on a valid/ready port
//  to the readout logic. Same clock domain as the POP timers.
// PARAMETERS
//  ADC_WIDTH   12  width of adc_data (unsigned)
//  ACC_WIDTH   32  width of result_sum; saturating
//  CNT_WIDTH   16  width of result_count; saturating
//  NUM_CYCLES  16  windows summed per result (>=1)
// PORTS
//  clock_2_5M       in   1          system clock; all logic on posedge
//  reset            in   1          synchronous, active-high; clears all state
//  sample           in   1          sample gate from POP timers (combinational source)
//  adc_data         in   ADC_WIDTH  ADC sample, aligned with registered gate (sample_q)
//  adc_valid        in   1          adc_data valid this cycle
//  result_sum       out  ACC_WIDTH  sum of accepted samples over NUM_CYCLES windows
//  result_count     out  CNT_WIDTH  number of samples in result_sum
//  result_valid     out  1          result held stable while high
//  result_ready     in   1          consumer accepts when result_valid & result_ready
//  overflow         out  1          result_sum or result_count saturated for this result
//  dropped_windows  out  8          windows discarded while HOLD; saturates at 255
// BEHAVIOUR
//  - Gate: sample_q <= sample each posedge; sample_q2 <= sample_q. rise = sample_q&!sample_q2,
//    fall = !sample_q&sample_q2. Sample accepted iff state==ACCUM & sample_q & adc_valid.
//  - Reset: all outputs 0, state IDLE, accumulators/window counter 0, sample_q/q2 0.
//  - FSM:
//    IDLE : rise -> ACCUM (sample of the rise cycle is accepted, i.e. the IDLE->ACCUM
//           edge check uses sample_q; accept logic treats rise cycle as ACCUM).
//    ACCUM: accept samples; win_sum += adc_data, win_cnt += 1. fall -> CLOSE.
//    CLOSE: one cycle. tot_sum += win_sum, tot_cnt += win_cnt, windows += 1, clear win_*.
//           windows==NUM_CYCLES -> HOLD (latch outputs, result_valid=1), else IDLE.
//    HOLD : outputs frozen. result_valid&result_ready -> clear tot_*, windows, overflow;
//           result_valid=0 next cycle; -> IDLE. Each rise seen in HOLD: dropped_windows+=1.
//  - Latency: result_valid rises 2 cycles after the fall cycle of the final window.
//  - A window already open (sample_q high) on entry to IDLE is ignored; wait for next rise.
//  - Handshake cycle coinciding with a rise: rise counted as dropped; window not accumulated.
//  - Arithmetic: all adds unsigned saturating (clamp at all-ones); any clamp sets
//    overflow, which is latched with the result and cleared on handshake.
//  - dropped_windows cleared only by reset.
//  - reset mid-window or mid-HOLD: discards partial sums; first result after reset uses
//    only windows whose rise occurs after reset deasserts.
// TESTING
//  1 NUM_CYCLES=2; two windows of 5 valid samples of 100, ready=1 -> result_sum=1000,
//    result_count=10, overflow=0, result_valid high exactly 1 cycle.
//  2 adc_valid toggling every cycle in 10-cycle windows, value 7, NUM_CYCLES=1 ->
//    result_count=5, result_sum=35.
//  3 ready=0 after result; three further gate pulses -> result unchanged,
//    dropped_windows=3; ready=1 -> valid drops next cycle, next result from new windows.
//  4 ACC_WIDTH=12, NUM_CYCLES=1, two samples of 4095 -> result_sum=4095, overflow=1;
//    after handshake, next clean result has overflow=0.
//  5 reset pulsed 3 cycles into a window -> all outputs 0; partial window excluded;
//    gate already high at reset release is ignored until next rising edge.
//  6 gate pulse of 1 cycle with adc_valid=1, value 9, NUM_CYCLES=1 -> result_sum=9,
//    result_count=1, result_valid 2 cycles after fall.

Source files
------------

// File: rtl/pop_sample_accumulator.sv
// ---------------------------------------------------------------------------
// pop_sample_accumulator
//
// Integrates ADC samples while the POP timer sample gate is high. One gate
// pulse is one window, and NUM_CYCLES consecutive windows are summed into one
// result. The result is offered to the readout logic on a valid/ready port.
// All sums are unsigned and saturating.
//
// Ports
//   clock_2_5M      in   system clock, all logic on posedge
//   reset           in   synchronous active-high reset, clears all state
//   sample          in   sample gate from the POP timers (registered here)
//   adc_data        in   ADC sample, aligned with the registered gate
//   adc_valid       in   adc_data valid this cycle
//   result_sum      out  saturated sum of accepted samples over the windows
//   result_count    out  saturated number of samples in result_sum
//   result_valid    out  result held stable while high
//   result_ready    in   consumer takes the result on valid & ready
//   overflow        out  a saturating add clamped while building this result
//   dropped_windows out  windows discarded while a result was pending
// ---------------------------------------------------------------------------
module pop_sample_accumulator #(
  parameter int ADC_WIDTH  = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int NUM_CYCLES = 16
) (
  input  logic                 clock_2_5M,
  input  logic                 reset,
  input  logic                 sample,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [ACC_WIDTH-1:0] result_sum,
  output logic [CNT_WIDTH-1:0] result_count,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 overflow,
  output logic [7:0]           dropped_windows
);

  localparam int WIN_W = $clog2(NUM_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CLOSE,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic                 sample_q, sample_q2;
  logic                 armed_q, armed_d;
  logic [ACC_WIDTH-1:0] win_sum_q, win_sum_d;
  logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_WIDTH-1:0] tot_sum_q, tot_sum_d;
  logic [CNT_WIDTH-1:0] tot_cnt_q, tot_cnt_d;
  logic [WIN_W-1:0]     windows_q, windows_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] result_sum_q, result_sum_d;
  logic [CNT_WIDTH-1:0] result_count_q, result_count_d;
  logic                 result_valid_q, result_valid_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           dropped_q, dropped_d;

  logic                 rise, fall, accept;
  logic [ACC_WIDTH-1:0] adc_ext;
  logic [ACC_WIDTH:0]   win_sum_add, tot_sum_add;
  logic [CNT_WIDTH:0]   win_cnt_add, tot_cnt_add;
  logic [ACC_WIDTH-1:0] win_sum_sat, tot_sum_sat;
  logic [CNT_WIDTH-1:0] win_cnt_sat, tot_cnt_sat;
  logic                 close_clamp;
  logic [WIN_W-1:0]     windows_inc;

  // armed_q blocks a gate that is already high when reset releases: a rise
  // only counts once the gate has been seen low outside of reset.
  assign rise   = sample_q & ~sample_q2 & armed_q;
  assign fall   = ~sample_q & sample_q2;
  // The rise cycle itself is treated as part of the window.
  assign accept = sample_q & adc_valid &
                  ((state_q == ST_ACCUM) | ((state_q == ST_IDLE) & rise));

  assign adc_ext     = ACC_WIDTH'(adc_data);
  assign win_sum_add = {1'b0, win_sum_q} + {1'b0, adc_ext};
  assign win_cnt_add = {1'b0, win_cnt_q} + (CNT_WIDTH + 1)'(1);
  assign tot_sum_add = {1'b0, tot_sum_q} + {1'b0, win_sum_q};
  assign tot_cnt_add = {1'b0, tot_cnt_q} + {1'b0, win_cnt_q};

  // Carry out of the widened add means the true sum exceeds all-ones.
  assign win_sum_sat = win_sum_add[ACC_WIDTH] ? '1 : win_sum_add[ACC_WIDTH-1:0];
  assign win_cnt_sat = win_cnt_add[CNT_WIDTH] ? '1 : win_cnt_add[CNT_WIDTH-1:0];
  assign tot_sum_sat = tot_sum_add[ACC_WIDTH] ? '1 : tot_sum_add[ACC_WIDTH-1:0];
  assign tot_cnt_sat = tot_cnt_add[CNT_WIDTH] ? '1 : tot_cnt_add[CNT_WIDTH-1:0];
  assign close_clamp = tot_sum_add[ACC_WIDTH] | tot_cnt_add[CNT_WIDTH];

  assign windows_inc = windows_q + WIN_W'(1);

  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q | ~sample;
    win_sum_d      = win_sum_q;
    win_cnt_d      = win_cnt_q;
    tot_sum_d      = tot_sum_q;
    tot_cnt_d      = tot_cnt_q;
    windows_d      = windows_q;
    ovf_d          = ovf_q;
    result_sum_d   = result_sum_q;
    result_count_d = result_count_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    dropped_d      = dropped_q;

    if (accept) begin
      win_sum_d = win_sum_sat;
      win_cnt_d = win_cnt_sat;
      if (win_sum_add[ACC_WIDTH] | win_cnt_add[CNT_WIDTH]) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (fall) begin
          state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        tot_sum_d = tot_sum_sat;
        tot_cnt_d = tot_cnt_sat;
        ovf_d     = ovf_q | close_clamp;
        windows_d = windows_inc;
        win_sum_d = '0;
        win_cnt_d = '0;
        if (windows_inc == WIN_W'(NUM_CYCLES)) begin
          state_d        = ST_HOLD;
          result_sum_d   = tot_sum_sat;
          result_count_d = tot_cnt_sat;
          overflow_d     = ovf_q | close_clamp;
          result_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A rise here is lost even if the handshake happens in the same cycle.
        if (rise && (dropped_q != 8'hFF)) begin
          dropped_d = dropped_q + 8'd1;
        end
        if (result_valid_q && result_ready) begin
          state_d        = ST_IDLE;
          tot_sum_d      = '0;
          tot_cnt_d      = '0;
          windows_d      = '0;
          ovf_d          = 1'b0;
          result_valid_d = 1'b0;
          overflow_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sample_q       <= 1'b0;
      sample_q2      <= 1'b0;
      // Arm only if the gate is low while reset is held.
      armed_q        <= ~sample;
      win_sum_q      <= '0;
      win_cnt_q      <= '0;
      tot_sum_q      <= '0;
      tot_cnt_q      <= '0;
      windows_q      <= '0;
      ovf_q          <= 1'b0;
      result_sum_q   <= '0;
      result_count_q <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      dropped_q      <= '0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample;
      sample_q2      <= sample_q;
      armed_q        <= armed_d;
      win_sum_q      <= win_sum_d;
      win_cnt_q      <= win_cnt_d;
      tot_sum_q      <= tot_sum_d;
      tot_cnt_q      <= tot_cnt_d;
      windows_q      <= windows_d;
      ovf_q          <= ovf_d;
      result_sum_q   <= result_sum_d;
      result_count_q <= result_count_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      dropped_q      <= dropped_d;
    end
  end

  assign result_sum      = result_sum_q;
  assign result_count    = result_count_q;
  assign result_valid    = result_valid_q;
  assign overflow        = overflow_q;
  assign dropped_windows = dropped_q;

endmodule
